// File: rtl/spi_regfile_pkg.sv
// Shared constants, FSM state type and frame-width helper for the SPI register-file peripheral.
package spi_regfile_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_BLOCKED,
    ST_IDLE,
    ST_FRAME
  } frame_state_e;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_regfile_if.sv
// SPI pin bundle: master drives select/clock/data-out, slave drives data-in and its pad enable.
interface spi_regfile_if;
  logic nCS;
  logic SCLK;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (output nCS, SCLK, COPI, input CIPO, cipo_oe);
  modport slave  (input nCS, SCLK, COPI, output CIPO, cipo_oe);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third flop for single-cycle rise/fall pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sh_q, sh_d;

  always_comb begin
    sh_d = {sh_q[1:0], async_i};
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= RST_VAL ? '1 : '0;
    else     sh_q <= sh_d;
  end

  assign sync_o = sh_q[1];
  assign rise_o = sh_q[1] & ~sh_q[2];
  assign fall_o = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/spi_regfile_peripheral.sv
// Mode-0 SPI peripheral: R/W + address + data frames into a small register file.
// Optional readback path on CIPO is compiled in with `define SPI_READBACK_EN.
module spi_regfile_peripheral
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = 5,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  spi_regfile_if.slave                 bus,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_HDR  = CNT_W'(ADDR_W + 1);
  localparam logic [ADDR_W:0]  NREG_L   = (ADDR_W + 1)'(NUM_REGS);

  logic ncs_s, ncs_rise, ncs_fall;
  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic copi_s, copi_rise_unused, copi_fall_unused;

  spi_sync_edge #(.RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .async_i(bus.nCS),
    .sync_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .async_i(bus.SCLK),
    .sync_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .async_i(bus.COPI),
    .sync_o(copi_s), .rise_o(copi_rise_unused), .fall_o(copi_fall_unused)
  );

  frame_state_e         state_q, state_d;
  logic [1:0]           settle_q, settle_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   sr_q, sr_d, sr_shift;
  logic [DATA_W-1:0]    regs_q [NUM_REGS];
  logic [DATA_W-1:0]    regs_d [NUM_REGS];
  logic                 wr_strobe_q, frame_err_q;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic                 commit, discard, sample;
  logic [ADDR_W-1:0]    wa;
  logic [DATA_W-1:0]    wd;

  assign sr_shift = {sr_q[FRAME_W-2:0], copi_s};
  assign wa       = sr_q[DATA_W +: ADDR_W];
  assign wd       = sr_q[DATA_W-1:0];

  // After reset the nCS synchroniser reads idle even if the bus is mid-frame, so
  // frames are only accepted once the real nCS level is known to be high.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    sr_d     = sr_q;
    commit   = 1'b0;
    discard  = 1'b0;
    sample   = 1'b0;
    unique case (state_q)
      ST_SETTLE: begin
        if (settle_q == 2'd3) state_d = ncs_s ? ST_IDLE : ST_BLOCKED;
        else                  settle_d = settle_q + 2'd1;
      end
      ST_BLOCKED: begin
        if (ncs_s) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_FRAME;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      ST_FRAME: begin
        if (ncs_rise) begin
          state_d = ST_IDLE;
          if (cnt_q != CNT_FULL) discard = 1'b1;
          else if (sr_q[FRAME_W-1] == RW_WRITE && {1'b0, wa} < NREG_L) commit = 1'b1;
        end else if (sclk_rise) begin
          sample = 1'b1;
          sr_d   = sr_shift;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_comb begin
    regs_d    = regs_q;
    wr_addr_d = wr_addr_q;
    if (commit) wr_addr_d = wa;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (commit && wa == ADDR_W'(k)) regs_d[k] = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SETTLE;
      settle_q    <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      regs_q      <= '{default: '0};
      wr_strobe_q <= 1'b0;
      frame_err_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      regs_q      <= regs_d;
      wr_strobe_q <= commit;
      frame_err_q <= discard;
      wr_addr_q   <= wr_addr_d;
    end
  end

  always_comb begin
    regs_out = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) regs_out[k*DATA_W +: DATA_W] = regs_q[k];
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  logic [DATA_W-1:0] tx_q, tx_d, rd_word;
  logic              oe_q, oe_d;

  // The falling edge right after the load keeps the MSB so the controller samples
  // it on the first data-phase rising edge; later falling edges advance.
  always_comb begin
    tx_d    = tx_q;
    oe_d    = oe_q;
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (sr_shift[ADDR_W-1:0] == ADDR_W'(k)) rd_word = regs_q[k];
    end
    if (state_q == ST_FRAME && ncs_rise) begin
      tx_d = '0;
      oe_d = 1'b0;
    end else if (sample && cnt_q == CNT_ADDR && sr_shift[ADDR_W] == RW_READ) begin
      tx_d = rd_word;
      oe_d = 1'b1;
    end else if (state_q == ST_FRAME && sclk_fall && oe_q && cnt_q > CNT_HDR) begin
      tx_d = {tx_q[DATA_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q <= '0;
      oe_q <= 1'b0;
    end else begin
      tx_q <= tx_d;
      oe_q <= oe_d;
    end
  end

  assign bus.CIPO    = oe_q & tx_q[DATA_W-1];
  assign bus.cipo_oe = oe_q;
`else
  logic rb_unused;
  assign rb_unused   = sclk_fall;
  assign bus.CIPO    = 1'b0;
  assign bus.cipo_oe = 1'b0;
`endif

endmodule
